// File: rtl/dffpipe_arst_sync.sv
// Enable-gated register pipeline with a synchronous active-low reset and a synchronized asynchronous reset request.
// Optional macro DFFPIPE_ARST_BYPASS_EN: raw ARST forces Q/VALID combinationally, without changing internal state timing.
module dffpipe_arst_sync #(
  parameter int              WIDTH         = 1,
  parameter int              DEPTH         = 1,
  parameter int              CLK_POLARITY  = 1,
  parameter int              ARST_POLARITY = 1,
  parameter logic [WIDTH-1:0] ARST_VALUE   = '0,
  parameter int              SYNC_STAGES   = 2
) (
  input  logic             CLK,
  input  logic             SRST_N,
  input  logic             ARST,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             VALID,
  output logic             ARST_ACTIVE
);

  localparam int             CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  FILL_MAX = CW'(DEPTH);
  localparam logic           ARST_LVL = (ARST_POLARITY != 0);

  logic clk_int;
  logic arst_raw;
  logic arst_active;

  logic [SYNC_STAGES-1:0]           sync_q, sync_d;
  logic [DEPTH-1:0][WIDTH-1:0]      stage_q, stage_d, shift_in;
  logic [CW-1:0]                    fill_q, fill_d;
  logic                             valid_q, valid_d;

  // Invert the clock for negedge operation so every flop shares one always_ff edge.
  generate
    if (CLK_POLARITY != 0) begin : g_clk_pos
      assign clk_int = CLK;
    end else begin : g_clk_neg
      assign clk_int = ~CLK;
    end
  endgenerate

  assign arst_raw    = (ARST == ARST_LVL);
  assign sync_d      = {sync_q[SYNC_STAGES-2:0], arst_raw};
  assign arst_active = sync_q[SYNC_STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_shift
      if (gi == 0) begin : g_head
        assign shift_in[gi] = D;
      end else begin : g_body
        assign shift_in[gi] = stage_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    stage_d = stage_q;
    fill_d  = fill_q;
    if (!SRST_N || arst_active) begin
      stage_d = {DEPTH{ARST_VALUE}};
      fill_d  = '0;
    end else if (EN) begin
      stage_d = shift_in;
      if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
    end
    valid_d = (fill_d == FILL_MAX);
  end

  // SRST_N clears the synchronizer as well, so a held ARST must re-propagate afterwards.
  always_ff @(posedge clk_int) begin
    if (!SRST_N) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
    stage_q <= stage_d;
    fill_q  <= fill_d;
    valid_q <= valid_d;
  end

  assign ARST_ACTIVE = arst_active;

`ifdef DFFPIPE_ARST_BYPASS_EN
  assign Q     = arst_raw ? ARST_VALUE : stage_q[DEPTH-1];
  assign VALID = arst_raw ? 1'b0 : valid_q;
`else
  assign Q     = stage_q[DEPTH-1];
  assign VALID = valid_q;
`endif

endmodule

// File: tb/tb_dffpipe_arst_sync.sv
// Directed bench for dffpipe_arst_sync at WIDTH=8, DEPTH=3, SYNC_STAGES=2, ARST_VALUE=A5.
module tb_dffpipe_arst_sync;

  localparam logic [7:0] AV = 8'hA5;

  logic       CLK = 1'b0;
  logic       SRST_N, ARST, EN;
  logic [7:0] D, Q;
  logic       VALID, ARST_ACTIVE;

  int vectors = 0;
  int miscompares = 0;

  dffpipe_arst_sync #(
    .WIDTH(8), .DEPTH(3), .CLK_POLARITY(1), .ARST_POLARITY(1),
    .ARST_VALUE(8'hA5), .SYNC_STAGES(2)
  ) dut (
    .CLK(CLK), .SRST_N(SRST_N), .ARST(ARST), .EN(EN), .D(D),
    .Q(Q), .VALID(VALID), .ARST_ACTIVE(ARST_ACTIVE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_srst();
    SRST_N = 1'b0; ARST = 1'b0; EN = 1'b0; D = 8'h00;
    tick();
    SRST_N = 1'b1;
  endtask

  task automatic test_reset();
    SRST_N = 1'b0; ARST = 1'b0; EN = 1'b1; D = 8'hFF;
    tick(); tick();
    vectors++;
    if (Q !== AV || VALID !== 1'b0 || ARST_ACTIVE !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: Q=%h VALID=%b ACT=%b required Q=%h VALID=0 ACT=0", Q, VALID, ARST_ACTIVE, AV);
    end
    $display("reset: Q=%h VALID=%b ACT=%b", Q, VALID, ARST_ACTIVE);
    SRST_N = 1'b1;
  endtask

  task automatic test_fill();
    logic [7:0] exp_q;
    logic       exp_v;
    do_srst();
    EN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      D = 8'(i + 1);
      tick();
      exp_q = (i < 2) ? AV : 8'(i - 1);
      exp_v = (i >= 2);
      vectors++;
      if (Q !== exp_q || VALID !== exp_v) begin
        miscompares++;
        $display("FAIL fill edge %0d: Q=%h VALID=%b required Q=%h VALID=%b", i + 1, Q, VALID, exp_q, exp_v);
      end
      $display("fill edge %0d: D=%h Q=%h VALID=%b", i + 1, D, Q, VALID);
    end
  endtask

  task automatic test_enable_gaps();
    logic       en_pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] d_pat  [5] = '{8'h11, 8'hEE, 8'h22, 8'hEE, 8'h33};
    logic [7:0] q_pat  [5] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h11};
    logic       v_pat  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_srst();
    for (int i = 0; i < 5; i++) begin
      EN = en_pat[i]; D = d_pat[i];
      tick();
      vectors++;
      if (Q !== q_pat[i] || VALID !== v_pat[i]) begin
        miscompares++;
        $display("FAIL enable_gaps edge %0d: Q=%h VALID=%b required Q=%h VALID=%b", i + 1, Q, VALID, q_pat[i], v_pat[i]);
      end
      $display("enable_gaps edge %0d: EN=%b D=%h Q=%h VALID=%b", i + 1, EN, D, Q, VALID);
    end
    EN = 1'b0;
  endtask

  task automatic test_arst();
    // edges 1-4: ARST high; edges 5-9: ARST low. D on edges 1-6 must never reach Q.
    logic       a_pat [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] d_pat [9] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h51, 8'h52, 8'h53};
    logic [7:0] q_pat [9] = '{8'h32, 8'h33, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h51};
    logic       v_pat [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       c_pat [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_srst();
    EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      D = 8'h31 + 8'(i);
      tick();
    end
    for (int i = 0; i < 9; i++) begin
      ARST = a_pat[i]; D = d_pat[i];
      tick();
      vectors++;
      if (Q !== q_pat[i] || VALID !== v_pat[i] || ARST_ACTIVE !== c_pat[i]) begin
        miscompares++;
        $display("FAIL arst edge %0d: Q=%h VALID=%b ACT=%b required Q=%h VALID=%b ACT=%b",
                 i + 1, Q, VALID, ARST_ACTIVE, q_pat[i], v_pat[i], c_pat[i]);
      end
      $display("arst edge %0d: ARST=%b D=%h Q=%h VALID=%b ACT=%b", i + 1, ARST, D, Q, VALID, ARST_ACTIVE);
    end
    EN = 1'b0;
  endtask

  task automatic test_srst_priority();
    logic [7:0] q_pat [3] = '{8'hA5, 8'hA5, 8'h77};
    do_srst();
    ARST = 1'b1; EN = 1'b0;
    tick(); tick();
    vectors++;
    if (ARST_ACTIVE !== 1'b1) begin
      miscompares++;
      $display("FAIL srst_prio arst_up: ACT=%b required 1", ARST_ACTIVE);
    end
    SRST_N = 1'b0; EN = 1'b1; D = 8'hFF;
    tick();
    vectors++;
    if (Q !== AV || VALID !== 1'b0 || ARST_ACTIVE !== 1'b0) begin
      miscompares++;
      $display("FAIL srst_prio edge: Q=%h VALID=%b ACT=%b required Q=%h VALID=0 ACT=0", Q, VALID, ARST_ACTIVE, AV);
    end
    $display("srst_prio edge: Q=%h VALID=%b ACT=%b", Q, VALID, ARST_ACTIVE);
    SRST_N = 1'b1; EN = 1'b0;
    tick();
    vectors++;
    if (ARST_ACTIVE !== 1'b0) begin
      miscompares++;
      $display("FAIL srst_prio resync1: ACT=%b required 0", ARST_ACTIVE);
    end
    tick();
    vectors++;
    if (ARST_ACTIVE !== 1'b1) begin
      miscompares++;
      $display("FAIL srst_prio resync2: ACT=%b required 1", ARST_ACTIVE);
    end
    $display("srst_prio resync: ACT=%b", ARST_ACTIVE);
    ARST = 1'b0;
    tick(); tick(); tick();
    // Load live data, then reset in mid-shift: every stage must come back as A5.
    EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      D = 8'h61 + 8'(i);
      tick();
    end
    SRST_N = 1'b0; D = 8'hFF;
    tick();
    SRST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      D = 8'h77 + 8'(i);
      tick();
      vectors++;
      if (Q !== q_pat[i]) begin
        miscompares++;
        $display("FAIL srst_flush edge %0d: Q=%h required %h", i + 1, Q, q_pat[i]);
      end
      $display("srst_flush edge %0d: Q=%h VALID=%b", i + 1, Q, VALID);
    end
    EN = 1'b0;
  endtask

  task automatic test_saturate();
    logic [7:0] exp_q;
    logic       exp_v;
    int         bad;
    do_srst();
    EN = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      D = 8'(i);
      tick();
      exp_q = (i < 2) ? AV : 8'(i - 2);
      exp_v = (i >= 2);
      vectors++;
      if (Q !== exp_q || VALID !== exp_v) begin
        miscompares++;
        bad++;
        if (bad <= 5)
          $display("FAIL saturate edge %0d: Q=%h VALID=%b required Q=%h VALID=%b", i + 1, Q, VALID, exp_q, exp_v);
      end
    end
    $display("saturate: 200 edges, last Q=%h VALID=%b", Q, VALID);
    EN = 1'b0;
  endtask

  task automatic test_bypass();
    logic [7:0] q_pat [3];
    logic       v_pat [3];
    do_srst();
    EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      D = 8'h81 + 8'(i);
      tick();
    end
    EN = 1'b0;
    #3 ARST = 1'b1;
    #1;
    vectors++;
`ifdef DFFPIPE_ARST_BYPASS_EN
    if (Q !== AV || VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL bypass midcycle: Q=%h VALID=%b required Q=%h VALID=0", Q, VALID, AV);
    end
    q_pat = '{8'hA5, 8'hA5, 8'hA5};
    v_pat = '{1'b0, 1'b0, 1'b0};
`else
    if (Q !== 8'h81 || VALID !== 1'b1) begin
      miscompares++;
      $display("FAIL bypass midcycle: Q=%h VALID=%b required Q=81 VALID=1", Q, VALID);
    end
    q_pat = '{8'h81, 8'h81, 8'hA5};
    v_pat = '{1'b1, 1'b1, 1'b0};
`endif
    $display("bypass midcycle: Q=%h VALID=%b", Q, VALID);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (Q !== q_pat[i] || VALID !== v_pat[i]) begin
        miscompares++;
        $display("FAIL bypass edge %0d: Q=%h VALID=%b required Q=%h VALID=%b", i + 1, Q, VALID, q_pat[i], v_pat[i]);
      end
      $display("bypass edge %0d: Q=%h VALID=%b", i + 1, Q, VALID);
    end
    ARST = 1'b0;
  endtask

  initial begin
    SRST_N = 1'b1; ARST = 1'b0; EN = 1'b0; D = 8'h00;
    test_reset();
    test_fill();
    test_enable_gaps();
    test_arst();
    test_srst_priority();
    test_saturate();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dffpipe_arst_sync.md
DFFPIPE_ARST_SYNC -- requirements
Module: dffpipe_arst_sync

Interface
REQ-001 SHALL have parameter WIDTH, default 1: data width in bits, legal range 1 or more.
REQ-002 SHALL have parameter DEPTH, default 1: number of register stages, legal range 1 to 16.
REQ-003 SHALL have parameter CLK_POLARITY, default 1: 1 = posedge active, 0 = negedge active.
REQ-004 SHALL have parameter ARST_POLARITY, default 1: asserted level of ARST.
REQ-005 SHALL have parameter ARST_VALUE, default 0: WIDTH-bit load value for all stages on any reset.
REQ-006 SHALL have parameter SYNC_STAGES, default 2: ARST synchronizer length, legal range 2 to 4.
REQ-007 SHALL have port CLK, input, 1 bit: the single clock, active edge per CLK_POLARITY.
REQ-008 SHALL have port SRST_N, input, 1 bit: reset, synchronous and active-low.
REQ-009 SHALL have port ARST, input, 1 bit: asynchronous reset request, treated as fully asynchronous to CLK.
REQ-010 SHALL have port EN, input, 1 bit: pipeline advance enable.
REQ-011 SHALL have port D, input, WIDTH bits: data in.
REQ-012 SHALL have port Q, output, WIDTH bits: last-stage data out.
REQ-013 SHALL have port VALID, output, 1 bit: Q holds data captured since the last reset.
REQ-014 SHALL have port ARST_ACTIVE, output, 1 bit: synchronized ARST, high = asserted.

Function
REQ-015 All state SHALL update only on the CLK active edge selected by CLK_POLARITY.
REQ-016 ARST SHALL pass through SYNC_STAGES flops, and the synchronized level SHALL drive ARST_ACTIVE directly.
REQ-017 Update priority per edge SHALL be: SRST_N low, then ARST_ACTIVE high, then EN high, then hold.
REQ-018 When ARST_ACTIVE is high, every stage SHALL load ARST_VALUE and the fill counter SHALL clear to 0.
REQ-019 EN high with no reset SHALL shift the pipeline: stage0 takes D, stage i takes stage i-1; Q is stage DEPTH-1.
REQ-020 EN low with no reset SHALL hold all stages and the fill counter.
REQ-021 Latency SHALL be DEPTH enabled edges from D capture to Q; disabled edges SHALL not count.
REQ-022 Fill counter SHALL be ceil(log2(DEPTH+1)) bits, SHALL increment on each enabled shift, and SHALL saturate at DEPTH without wrapping.
REQ-023 VALID SHALL be high only when fill counter equals DEPTH; it SHALL be registered, with no combinational path from EN.
REQ-024 ARST assert SHALL produce Q = ARST_VALUE after SYNC_STAGES+1 edges; deassert SHALL end the reset hold after SYNC_STAGES edges, and the next edge SHALL resume normal shift.
REQ-025 If ARST is asserted while EN is high, the ARST_ACTIVE edge SHALL win, and D on that edge SHALL be discarded.
REQ-026 An ARST pulse shorter than one clock period SHALL either be fully applied or fully ignored, with no partial stage corruption.

Reset
REQ-027 SRST_N low at an active edge SHALL set all stages to ARST_VALUE, the fill counter to 0, VALID to 0, and ARST_ACTIVE to 0 (sync chain cleared to deasserted).
REQ-028 SRST_N low SHALL override ARST_ACTIVE and EN on the same edge; reset during a shift SHALL discard in-flight data.
REQ-029 After SRST_N rises, a still-asserted ARST SHALL again require SYNC_STAGES edges to reach ARST_ACTIVE.

Configuration
REQ-030 Macro DFFPIPE_ARST_BYPASS_EN defined: Q SHALL be forced combinationally to ARST_VALUE whenever raw ARST equals ARST_POLARITY, and VALID SHALL be forced to 0 in the same way (equivalent to an asynchronous-reset output view); internal state timing SHALL be unchanged.
REQ-031 Macro DFFPIPE_ARST_BYPASS_EN undefined: Q and VALID SHALL be purely registered, and ARST SHALL affect them only per REQ-024.

Verification (WIDTH=8, DEPTH=3, SYNC_STAGES=2, ARST_VALUE=8'hA5, ARST_POLARITY=1)
REQ-032 Scenario 1: SRST_N low for 1 edge, then EN=1 with D=01,02,03,04 -> Q=A5 and VALID=0 for 2 edges; Q=01 with VALID=1 after the 3rd edge; then Q=02, 03, 04.
REQ-033 Scenario 2: EN toggles 1,0,1,0,1 with D=11 on the first enabled edge -> Q=11 after the 3rd enabled edge; VALID rises on that same edge.
REQ-034 Scenario 3: full pipe, ARST=1 -> ARST_ACTIVE=1 after 2 edges, Q=A5 and VALID=0 after the 3rd edge; ARST=0 -> ARST_ACTIVE=0 after 2 edges, and VALID returns 3 enabled edges later.
REQ-035 Scenario 4: SRST_N=0 and ARST_ACTIVE=1 on the same edge, with D=FF and EN=1 -> all stages A5; ARST_ACTIVE=0 on the next edge despite ARST=1.
REQ-036 Scenario 5: 200 enabled edges -> fill counter stays at 3, with no wrap and no VALID glitch.
REQ-037 Scenario 6: DFFPIPE_ARST_BYPASS_EN defined, ARST rises mid-cycle -> Q=A5 and VALID=0 before the next edge; undefined -> Q changes only after 3 edges.
